// File: rtl/rv_burst_source_if.sv
// Valid/ready stream bundle carried between a producer and a consumer.
// master: the producer drives valid/data/last and receives ready.
// slave: the consumer drives ready and receives valid/data/last.
interface rv_burst_source_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  valid_out;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  last_out;

  modport master (
    output valid_out,
    output data_out,
    output last_out,
    input  ready_in
  );

  modport slave (
    input  valid_out,
    input  data_out,
    input  last_out,
    output ready_in
  );
endinterface

// File: rtl/rv_burst_source.sv
// rv_burst_source: valid/ready producer that emits a burst of incrementing
// data words on a start command, with an optional idle gap between words.
// valid_out is held high and data_out stays stable until the handshake.
// Every output comes from a register, so nothing depends combinationally
// on ready_in.
// Optional build macro RV_SRC_STALL_CNT_EN adds a 16-bit saturating
// stall_count output. It counts SEND cycles with ready_in low, clears when
// a start is accepted, and holds its value after the burst finishes.
module rv_burst_source #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  rv_burst_source_if.master     bus,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] start_value,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [GAP_WIDTH-1:0]  gap,
  output logic                  busy,
  output logic                  done
`ifdef RV_SRC_STALL_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [GAP_WIDTH-1:0]  gap_reg_r;
  logic [GAP_WIDTH-1:0]  gap_cnt_r;
  logic                  valid_r;
  logic                  last_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  handshake_s;

  assign handshake_s = valid_r & bus.ready_in;

  // Burst sequencer: state, data and counters, plus the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      data_r      <= {DATA_WIDTH{1'b0}};
      remaining_r <= {LEN_WIDTH{1'b0}};
      gap_reg_r   <= {GAP_WIDTH{1'b0}};
      gap_cnt_r   <= {GAP_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            if (burst_len != {LEN_WIDTH{1'b0}}) begin
              data_r      <= start_value;
              remaining_r <= burst_len;
              gap_reg_r   <= gap;
              valid_r     <= 1'b1;
              last_r      <= (burst_len == LEN_WIDTH'(1));
              busy_r      <= 1'b1;
              state_r     <= ST_SEND;
            end else begin
              // A zero-length burst sends nothing but still reports done.
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SEND: begin
          if (handshake_s) begin
            if (remaining_r == LEN_WIDTH'(1)) begin
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              data_r      <= data_r + DATA_WIDTH'(1);
              remaining_r <= remaining_r - LEN_WIDTH'(1);
              if (gap_reg_r == {GAP_WIDTH{1'b0}}) begin
                // Full rate: the next word is offered in the following cycle.
                last_r  <= (remaining_r == LEN_WIDTH'(2));
                state_r <= ST_SEND;
              end else begin
                valid_r   <= 1'b0;
                last_r    <= 1'b0;
                gap_cnt_r <= gap_reg_r;
                state_r   <= ST_GAP;
              end
            end
          end else begin
            // Hold: the offered word stays untouched until it is taken.
            state_r <= ST_SEND;
          end
        end

        ST_GAP: begin
          if (gap_cnt_r == GAP_WIDTH'(1)) begin
            valid_r <= 1'b1;
            last_r  <= (remaining_r == LEN_WIDTH'(1));
            state_r <= ST_SEND;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
            state_r   <= ST_GAP;
          end
        end

        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RV_SRC_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of SEND cycles in which the consumer withheld ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_IDLE) && start) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_SEND) && !bus.ready_in && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;
`endif

  assign bus.valid_out = valid_r;
  assign bus.data_out  = data_r;
  assign bus.last_out  = last_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule
